// File: rtl/hwpe_ctrl_offload_master.sv
// Initiator side of the HWPE peripheral control port. It acquires a context by
// test&set, programs the job registers, triggers the job and waits for completion.
module hwpe_ctrl_offload_master #(
  parameter int unsigned N_JOB_REGS     = 8,
  parameter int unsigned ID_WIDTH       = 16,
  parameter int unsigned CORE_ID        = 0,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned REG_OFFSET     = 8,
  parameter int unsigned BACKOFF_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  localparam int unsigned NW            = $clog2(N_JOB_REGS + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    job_valid_i,
  output logic                    job_ready_o,
  input  logic [NW-1:0]           job_nregs_i,
  input  logic [N_JOB_REGS*32-1:0] job_regs_i,
  input  logic                    done_evt_i,
  output logic                    busy_o,
  output logic [31:0]             job_ctx_o,
  output logic                    job_done_o,
  output logic                    err_o,
  output logic                    cfg_req,
  input  logic                    cfg_gnt,
  output logic [31:0]             cfg_add,
  output logic                    cfg_wen,
  output logic [3:0]              cfg_be,
  output logic [31:0]             cfg_data,
  output logic [ID_WIDTH-1:0]     cfg_id,
  input  logic [31:0]             cfg_r_data,
  input  logic                    cfg_r_valid,
  input  logic [ID_WIDTH-1:0]     cfg_r_id
);

  localparam int unsigned BCW = $clog2(BACKOFF_CYCLES + 1);
  localparam int unsigned TCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [ID_WIDTH-1:0] MY_ID = ID_WIDTH'(1) << CORE_ID;
  localparam logic [NW-1:0] N_MAX = NW'(N_JOB_REGS);
  localparam logic [31:0] WORD_TRIG = 32'd0;
  localparam logic [31:0] WORD_ACQ  = 32'd1;
  localparam logic [31:0] WORD_CLR  = 32'd5;

  typedef enum logic [2:0] {
    IDLE, ACQ, ACQ_WAIT, BACKOFF, WR, TRIG, WAIT, CLR
  } state_t;

  state_t                  state;
  logic [N_JOB_REGS*32-1:0] regs_q;
  logic [NW-1:0]           n_q;
  logic [NW-1:0]           k_q;
  logic [BCW-1:0]          bcnt_q;
  logic [TCW-1:0]          tcnt_q;

  function automatic logic [31:0] word_addr(input logic [31:0] w);
    word_addr = BASE_ADDR + (w << 2);
  endfunction

  assign cfg_be      = 4'hF;
  assign busy_o      = (state != IDLE);
  assign job_ready_o = (state == IDLE);

  // Every request is loaded in the same edge that moves into the state owning it,
  // and its fields are only touched again on the edge that sees the grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cfg_req    <= 1'b0;
      cfg_add    <= 32'h0;
      cfg_wen    <= 1'b1;
      cfg_data   <= 32'h0;
      cfg_id     <= '0;
      job_done_o <= 1'b0;
      err_o      <= 1'b0;
      job_ctx_o  <= 32'h0;
      regs_q     <= '0;
      n_q        <= '0;
      k_q        <= '0;
      bcnt_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      job_done_o <= 1'b0;
      err_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (job_valid_i) begin
            regs_q   <= job_regs_i;
            n_q      <= (job_nregs_i > N_MAX) ? N_MAX : job_nregs_i;
            cfg_req  <= 1'b1;
            cfg_wen  <= 1'b1;
            cfg_add  <= word_addr(WORD_ACQ);
            cfg_data <= 32'h0;
            cfg_id   <= MY_ID;
            state    <= ACQ;
          end
        end
        ACQ: begin
          if (cfg_gnt) begin
            cfg_req <= 1'b0;
            state   <= ACQ_WAIT;
          end
        end
        ACQ_WAIT: begin
          // Responses tagged for another initiator share the bus and are skipped.
          if (cfg_r_valid && cfg_r_id == MY_ID) begin
            if (cfg_r_data[31]) begin
              bcnt_q <= '0;
              state  <= BACKOFF;
            end else begin
              job_ctx_o <= cfg_r_data;
              k_q       <= '0;
              cfg_req   <= 1'b1;
              cfg_wen   <= 1'b0;
              cfg_id    <= MY_ID;
              if (n_q != '0) begin
                cfg_add  <= word_addr(32'(REG_OFFSET));
                cfg_data <= regs_q[31:0];
                state    <= WR;
              end else begin
                cfg_add  <= word_addr(WORD_TRIG);
                cfg_data <= 32'h0;
                state    <= TRIG;
              end
            end
          end
        end
        BACKOFF: begin
          if (bcnt_q == BCW'(BACKOFF_CYCLES - 1)) begin
            cfg_req  <= 1'b1;
            cfg_wen  <= 1'b1;
            cfg_add  <= word_addr(WORD_ACQ);
            cfg_data <= 32'h0;
            cfg_id   <= MY_ID;
            state    <= ACQ;
          end else begin
            bcnt_q <= bcnt_q + BCW'(1);
          end
        end
        WR: begin
          if (cfg_gnt) begin
            if (k_q == n_q - NW'(1)) begin
              cfg_add  <= word_addr(WORD_TRIG);
              cfg_data <= 32'h0;
              state    <= TRIG;
            end else begin
              k_q      <= k_q + NW'(1);
              cfg_add  <= word_addr(32'(REG_OFFSET) + 32'(k_q) + 32'd1);
              cfg_data <= regs_q[32*(int'(k_q)+1) +: 32];
            end
          end
        end
        TRIG: begin
          if (cfg_gnt) begin
            cfg_req <= 1'b0;
            tcnt_q  <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // A completion arriving on the expiry cycle still counts as success.
          if (done_evt_i) begin
            job_done_o <= 1'b1;
            state      <= IDLE;
          end else if (TIMEOUT_CYCLES != 0 && tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
            cfg_req  <= 1'b1;
            cfg_wen  <= 1'b0;
            cfg_add  <= word_addr(WORD_CLR);
            cfg_data <= 32'h0;
            cfg_id   <= MY_ID;
            state    <= CLR;
          end else if (tcnt_q != '1) begin
            tcnt_q <= tcnt_q + TCW'(1);
          end
        end
        CLR: begin
          if (cfg_gnt) begin
            cfg_req <= 1'b0;
            err_o   <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_offload_master.sv
// Directed bench for hwpe_ctrl_offload_master with a reactive control-slave model
// that logs every granted request and answers acquires from a scripted queue.
module tb_hwpe_ctrl_offload_master;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam logic [31:0] RA = 32'hAAAA_0001;
  localparam logic [31:0] RB = 32'hBBBB_0002;
  localparam logic [31:0] RC = 32'hCCCC_0003;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [3:0]   job_nregs = '0;
  logic [255:0] job_regs = '0;
  logic         done_evt = 1'b0;
  logic         busy, job_done, err;
  logic [31:0]  job_ctx;
  logic         cfg_req, cfg_gnt, cfg_wen, cfg_r_valid;
  logic [31:0]  cfg_add, cfg_data, cfg_r_data;
  logic [3:0]   cfg_be;
  logic [15:0]  cfg_id, cfg_r_id;

  typedef struct {
    logic        wen;
    logic [31:0] add;
    logic [31:0] data;
    int          cyc;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] acq_q[$];
  int cyc = 0;
  int accept_cyc = 0;
  int trig_cnt = 0;
  int trig_base = 0;
  int compared = 0;
  int mismatched = 0;
  logic [255:0] regs8;

  hwpe_ctrl_offload_master #(
    .N_JOB_REGS(8), .ID_WIDTH(16), .CORE_ID(2), .BASE_ADDR(BASE),
    .REG_OFFSET(8), .BACKOFF_CYCLES(16), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .job_valid_i(job_valid), .job_ready_o(job_ready),
    .job_nregs_i(job_nregs), .job_regs_i(job_regs),
    .done_evt_i(done_evt), .busy_o(busy), .job_ctx_o(job_ctx),
    .job_done_o(job_done), .err_o(err),
    .cfg_req(cfg_req), .cfg_gnt(cfg_gnt), .cfg_add(cfg_add), .cfg_wen(cfg_wen),
    .cfg_be(cfg_be), .cfg_data(cfg_data), .cfg_id(cfg_id),
    .cfg_r_data(cfg_r_data), .cfg_r_valid(cfg_r_valid), .cfg_r_id(cfg_r_id)
  );

  always #5 clk = ~clk;

  // Slave model: one-cycle response latency; write responses carry junk data.
  always @(posedge clk) begin
    txn_t t;
    cyc <= cyc + 1;
    cfg_r_valid <= 1'b0;
    if (job_valid && job_ready) accept_cyc <= cyc;
    if (cfg_req && cfg_gnt) begin
      t.wen = cfg_wen; t.add = cfg_add; t.data = cfg_data; t.cyc = cyc;
      log_q.push_back(t);
      cfg_r_valid <= 1'b1;
      cfg_r_id    <= cfg_id;
      if (cfg_wen) begin
        if (acq_q.size() > 0) cfg_r_data <= acq_q.pop_front();
        else cfg_r_data <= 32'h0;
      end else begin
        cfg_r_data <= 32'hDEAD_BEEF;
        if (cfg_add == BASE) trig_cnt <= trig_cnt + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkTxn(input string tag, input int idx, input logic wen,
                          input logic [31:0] add, input logic [31:0] data, input logic use_data);
    logic [64:0] obs;
    obs = 'x;
    if (idx < log_q.size())
      obs = {log_q[idx].wen, log_q[idx].add, use_data ? log_q[idx].data : 32'h0};
    checkOutput(tag, obs, {wen, add, use_data ? data : 32'h0});
  endtask

  task automatic checkCyc(input string tag, input int idx, input int rel);
    int obs;
    obs = -1;
    if (idx < log_q.size()) obs = log_q[idx].cyc - accept_cyc;
    checkOutput(tag, obs, rel);
  endtask

  task automatic applyStimulus(input logic [3:0] nregs, input logic [255:0] regs);
    @(negedge clk);
    log_q.delete();
    trig_base = trig_cnt;
    job_nregs = nregs;
    job_regs  = regs;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic finishJob(input string tag, input logic [31:0] ctx_exp);
    for (int i = 0; i < 300 && trig_cnt == trig_base; i++) @(negedge clk);
    checkOutput({tag, "_trig_seen"}, trig_cnt != trig_base, 1);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_busy_in_wait"}, {busy, job_ready}, 2'b10);
    done_evt = 1'b1;
    @(negedge clk);
    done_evt = 1'b0;
    checkOutput({tag, "_done_pulse"}, job_done, 1);
    checkOutput({tag, "_ctx"}, job_ctx, ctx_exp);
    @(negedge clk);
    checkOutput({tag, "_done_clear"}, {job_done, busy, job_ready}, 3'b001);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 8; k++) regs8[32*k +: 32] = 32'h1000_0000 + 32'(k);
    cfg_gnt = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_req", cfg_req, 0);
    checkOutput("rst_add", cfg_add, 0);
    checkOutput("rst_wen_be", {cfg_wen, cfg_be}, 5'h1F);
    checkOutput("rst_data_id", {cfg_data, cfg_id}, 0);
    checkOutput("rst_flags", {job_done, err, busy, job_ready}, 4'b0001);
    checkOutput("rst_ctx", job_ctx, 0);
    rst_i = 1'b0;

    // Basic three-register job.
    acq_q.push_back(32'h0);
    applyStimulus(4'd3, {160'h0, RC, RB, RA});
    checkOutput("t1_busy", {busy, job_ready, cfg_req, cfg_id}, {3'b101, 16'h0004});
    finishJob("t1", 32'h0);
    checkOutput("t1_count", log_q.size(), 5);
    checkTxn("t1_acq", 0, 1'b1, BASE + 4, 32'h0, 1'b0);
    checkTxn("t1_w0", 1, 1'b0, BASE + 32, RA, 1'b1);
    checkTxn("t1_w1", 2, 1'b0, BASE + 36, RB, 1'b1);
    checkTxn("t1_w2", 3, 1'b0, BASE + 40, RC, 1'b1);
    checkTxn("t1_trig", 4, 1'b0, BASE, 32'h0, 1'b1);
    checkCyc("t1_acq_cyc", 0, 1);
    checkCyc("t1_w0_cyc", 1, 3);
    checkCyc("t1_trig_cyc", 4, 6);

    // Two full responses followed by success.
    acq_q.push_back(32'hFFFF_FFFF);
    acq_q.push_back(32'hFFFF_FFFF);
    acq_q.push_back(32'h1);
    applyStimulus(4'd1, {224'h0, 32'h1234_5678});
    finishJob("t2", 32'h1);
    checkOutput("t2_count", log_q.size(), 5);
    checkTxn("t2_acq1", 1, 1'b1, BASE + 4, 32'h0, 1'b0);
    checkTxn("t2_acq2", 2, 1'b1, BASE + 4, 32'h0, 1'b0);
    checkCyc("t2_acq1_cyc", 1, 19);
    checkCyc("t2_acq2_cyc", 2, 37);
    checkTxn("t2_w0", 3, 1'b0, BASE + 32, 32'h1234_5678, 1'b1);
    checkCyc("t2_w0_cyc", 3, 39);

    // Grant withheld for five cycles on the second job write.
    acq_q.push_back(32'h2);
    applyStimulus(4'd3, {160'h0, RC, RB, RA});
    for (int i = 0; i < 50 && !(cfg_req && !cfg_wen && cfg_add == BASE + 36); i++)
      @(negedge clk);
    checkOutput("t3_second_write_seen", cfg_req && !cfg_wen && cfg_add == BASE + 36, 1);
    cfg_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t3_stall_stable", {cfg_req, cfg_wen, cfg_add, cfg_data},
                  {1'b1, 1'b0, BASE + 36, RB});
    end
    cfg_gnt = 1'b1;
    finishJob("t3", 32'h2);
    checkOutput("t3_count", log_q.size(), 5);
    checkTxn("t3_w0", 1, 1'b0, BASE + 32, RA, 1'b1);
    checkTxn("t3_w1", 2, 1'b0, BASE + 36, RB, 1'b1);
    checkTxn("t3_w2", 3, 1'b0, BASE + 40, RC, 1'b1);
    checkCyc("t3_w1_cyc", 2, 9);
    checkCyc("t3_trig_cyc", 4, 11);

    // Register count above the maximum is clamped.
    acq_q.push_back(32'h3);
    applyStimulus(4'd15, regs8);
    finishJob("t4", 32'h3);
    checkOutput("t4_count", log_q.size(), 10);
    checkTxn("t4_first", 1, 1'b0, BASE + 32, 32'h1000_0000, 1'b1);
    checkTxn("t4_last", 8, 1'b0, BASE + 60, 32'h1000_0007, 1'b1);
    checkTxn("t4_trig", 9, 1'b0, BASE, 32'h0, 1'b1);
    checkCyc("t4_trig_cyc", 9, 11);

    // Zero registers and no completion: direct trigger, then timeout and soft clear.
    acq_q.push_back(32'h0);
    applyStimulus(4'd0, 256'h0);
    for (int i = 0; i < 300 && !err; i++) @(negedge clk);
    checkOutput("t5_err_pulse", err, 1);
    checkOutput("t5_idle_after", {busy, job_ready, job_done}, 3'b010);
    checkOutput("t5_count", log_q.size(), 3);
    checkTxn("t5_trig", 1, 1'b0, BASE, 32'h0, 1'b1);
    checkCyc("t5_trig_cyc", 1, 3);
    checkTxn("t5_clr", 2, 1'b0, BASE + 20, 32'h0, 1'b1);
    checkOutput("t5_clr_delay", (log_q.size() == 3) ? log_q[2].cyc - log_q[1].cyc : -1, 101);
    @(negedge clk);
    checkOutput("t5_err_clear", err, 0);

    // Reset in the middle of the job writes, then a stray completion.
    acq_q.push_back(32'h5);
    applyStimulus(4'd8, regs8);
    for (int i = 0; i < 50 && !(cfg_req && !cfg_wen && cfg_add == BASE + 40); i++)
      @(negedge clk);
    checkOutput("t6_in_wr", cfg_req && !cfg_wen && cfg_add == BASE + 40, 1);
    checkOutput("t6_ctx_before", job_ctx, 32'h5);
    rst_i = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_state", {cfg_req, busy, job_ready}, 3'b001);
    checkOutput("t6_rst_ctx_add", {job_ctx, cfg_add}, 64'h0);
    rst_i = 1'b0;
    @(negedge clk);
    done_evt = 1'b1;
    @(negedge clk);
    done_evt = 1'b0;
    checkOutput("t6_stray_done", job_done, 0);
    @(negedge clk);
    checkOutput("t6_stray_done_after", {job_done, busy, job_ready}, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
